// File: rtl/pipe_fft_pkg.sv
// rtl/pipe_fft_pkg.sv - shared types and helpers for the pipelined-FFT delay line
// Purpose: state encoding for the delay-line controller and a constant
//          ceil(log2) helper used to size pointers and length fields.
// Ports:   none (package).
package pipe_fft_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,  // line not yet primed, output masked
    RUN  = 2'd1,  // steady state, output valid
    BYP  = 2'd2   // zero-length line, register-only path
  } dly_state_t;

  // ceil(log2(n)), never less than 1 so a one-entry field still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_fft_dly_ram.sv
// rtl/pipe_fft_dly_ram.sv - simple dual-port storage with registered read
// Purpose: DEPTH x W memory, single clock, synchronous write, registered
//          read-first behaviour on a same-address collision, contents not reset.
// Ports:   clk      - rising-edge clock
//          re_i     - read enable (updates rdata_o)
//          raddr_i  - read address
//          we_i     - write enable
//          waddr_i  - write address
//          wdata_i  - write data
//          rdata_o  - registered read data (holds when re_i=0)
module pipe_fft_dly_ram #(
  parameter int W     = 68,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Non-blocking read and write in the same block give read-first:
  // a collision returns the old word.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_fft_dly_line.sv
// rtl/pipe_fft_dly_line.sv - run-time programmable delay line for FFT butterfly stages
// Purpose: delays a W-bit word by LEN enabled cycles (LEN 0..DEPTH, loadable),
//          masks output until primed, flags out-of-range lengths.
// Ports:   clk     - rising-edge clock
//          nGrst   - asynchronous reset, active low
//          en      - advance the line / data-valid strobe
//          din     - input word, captured on en
//          len_ld  - load delay length from len_in
//          len_in  - requested delay length
//          flush   - restart fill, keep length
//          dout    - delayed word
//          primed  - line has seen LEN en-cycles since load/flush/reset
//          cfg_err - sticky out-of-range length flag, cleared by a legal load
module pipe_fft_dly_line
  import pipe_fft_pkg::*;
#(
  parameter int W       = 68,
  parameter int DEPTH   = 16,
  parameter int DEF_LEN = 16
) (
  input  logic                        clk,
  input  logic                        nGrst,
  input  logic                        en,
  input  logic [W-1:0]                din,
  input  logic                        len_ld,
  input  logic [clog2(DEPTH+1)-1:0]   len_in,
  input  logic                        flush,
  output logic [W-1:0]                dout,
  output logic                        primed,
  output logic                        cfg_err
);

  localparam int LW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] DEF_L   = LW'(DEF_LEN);
  localparam dly_state_t    RST_ST  = (DEF_LEN == 0) ? BYP : FILL;

  dly_state_t    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] fill_q, fill_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  byp_q, byp_d;
  logic          adv;
  logic [LW-1:0] len_clamp;
  logic          ptr_last;
  logic [W-1:0]  rdata;

  assign len_clamp = (len_in > DEPTH_L) ? DEPTH_L : len_in;
  assign ptr_last  = (LW'(ptr_q) == (len_q - LW'(1)));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    vld_d   = vld_q;
    byp_d   = byp_q;
    adv     = 1'b0;

    if (len_ld) begin
      len_d   = len_clamp;
      err_d   = (len_in > DEPTH_L);
      ptr_d   = '0;
      fill_d  = '0;
      vld_d   = 1'b0;
      byp_d   = '0;
      state_d = (len_clamp == '0) ? BYP : FILL;
    end else if (flush) begin
      ptr_d   = '0;
      fill_d  = '0;
      vld_d   = 1'b0;
      byp_d   = '0;
      state_d = (len_q == '0) ? BYP : FILL;
    end else if (en) begin
      case (state_q)
        BYP: byp_d = din;
        FILL: begin
          adv    = 1'b1;
          fill_d = fill_q + LW'(1);
          if (fill_q == (len_q - LW'(1))) state_d = RUN;
        end
        RUN: begin
          adv   = 1'b1;
          // The read on this edge hits a word written len_q edges ago,
          // so from here on the RAM output is genuine data.
          vld_d = 1'b1;
        end
        default: state_d = RST_ST;
      endcase
    end

    if (adv) ptr_d = ptr_last ? '0 : ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state_q <= RST_ST;
      len_q   <= DEF_L;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      fill_q  <= '0;
      vld_q   <= 1'b0;
      byp_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      byp_q   <= byp_d;
    end
  end

  // Gating with nGrst keeps a write from landing while reset is held.
  pipe_fft_dly_ram #(
    .W    (W),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_ram (
    .clk    (clk),
    .re_i   (adv & nGrst),
    .raddr_i(ptr_q),
    .we_i   (adv & nGrst),
    .waddr_i(ptr_q),
    .wdata_i(din),
    .rdata_o(rdata)
  );

  // RAM read data is masked until a RUN-state read has landed, which also
  // hides the stale word fetched on the edge that enters RUN.
  assign dout    = (state_q == BYP) ? byp_q : (vld_q ? rdata : '0);
  assign primed  = (state_q != FILL);
  assign cfg_err = err_q;

endmodule

// File: tb/tb_pipe_fft_dly_line.sv
// tb/tb_pipe_fft_dly_line.sv - self-checking bench for pipe_fft_dly_line
module tb_pipe_fft_dly_line;

  localparam int W = 68;
  localparam int DEPTH = 16;
  localparam int DEF_LEN = 16;

  logic          clk;
  logic          nGrst;
  logic          en;
  logic [W-1:0]  din;
  logic          len_ld;
  logic [4:0]    len_in;
  logic          flush;
  logic [W-1:0]  dout;
  logic          primed;
  logic          cfg_err;

  int tests;
  int fails;

  // Reference model: history of words captured since the last restart.
  logic [W-1:0] hist[$];
  int           n_m;
  int           len_m;
  logic         err_m;
  logic [W-1:0] byp_m;

  pipe_fft_dly_line #(.W(W), .DEPTH(DEPTH), .DEF_LEN(DEF_LEN)) dut (
    .clk(clk), .nGrst(nGrst), .en(en), .din(din), .len_ld(len_ld),
    .len_in(len_in), .flush(flush), .dout(dout), .primed(primed), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_restart();
    hist.delete();
    n_m = 0;
    byp_m = '0;
  endtask

  task automatic model_reset();
    len_m = DEF_LEN;
    err_m = 1'b0;
    model_restart();
  endtask

  function automatic logic [W-1:0] model_dout();
    if (len_m == 0) return byp_m;
    if (n_m > len_m) return hist[n_m - len_m - 1];
    return '0;
  endfunction

  function automatic logic model_primed();
    return (len_m == 0) || (n_m >= len_m);
  endfunction

  task automatic step(input logic e, input logic [W-1:0] d, input logic l,
                      input logic [4:0] li, input logic f);
    @(negedge clk);
    en = e; din = d; len_ld = l; len_in = li; flush = f;
    @(posedge clk);
    #1;
    if (l) begin
      len_m = (int'(li) > DEPTH) ? DEPTH : int'(li);
      err_m = (int'(li) > DEPTH);
      model_restart();
    end else if (f) begin
      model_restart();
    end else if (e) begin
      hist.push_back(d);
      n_m++;
      if (len_m == 0) byp_m = d;
    end
    check("model_dout", dout, model_dout());
    check("model_primed", W'(primed), W'(model_primed()));
    check("model_cfg_err", W'(cfg_err), W'(err_m));
  endtask

  typedef struct {
    logic         en;
    logic [W-1:0] din;
    logic         ld;
    logic [4:0]   len;
    logic         flush;
    logic [W-1:0] exp_dout;
    logic         exp_primed;
    logic         exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    tests = 0;
    fails = 0;
    nGrst = 1'b0;
    en = 1'b0; din = '0; len_ld = 1'b0; len_in = '0; flush = 1'b0;
    model_reset();

    // Bypass, clamping and priority vectors
    vecs[0]  = '{1'b0, 68'h0,  1'b1, 5'd0,  1'b0, 68'h0,  1'b1, 1'b0};
    vecs[1]  = '{1'b1, 68'hA5, 1'b0, 5'd0,  1'b0, 68'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 68'h33, 1'b0, 5'd0,  1'b0, 68'hA5, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 68'h5A, 1'b0, 5'd0,  1'b0, 68'h5A, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 68'h0,  1'b1, 5'd1,  1'b0, 68'h0,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 68'h11, 1'b0, 5'd0,  1'b0, 68'h0,  1'b1, 1'b0};
    vecs[6]  = '{1'b1, 68'h22, 1'b0, 5'd0,  1'b0, 68'h11, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 68'h44, 1'b0, 5'd0,  1'b0, 68'h11, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 68'h55, 1'b1, 5'd3,  1'b1, 68'h0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 68'h9,  1'b0, 5'd0,  1'b1, 68'h0,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 68'h0,  1'b1, 5'd20, 1'b0, 68'h0,  1'b0, 1'b1};
    vecs[11] = '{1'b1, 68'h7,  1'b0, 5'd0,  1'b0, 68'h0,  1'b0, 1'b1};

    #2;
    check("reset_dout", dout, '0);
    check("reset_primed", W'(primed), '0);
    check("reset_cfg_err", W'(cfg_err), '0);
    #10 nGrst = 1'b1;

    // T1: continuous ramp with default length 16
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, W'(k), 1'b0, 5'd0, 1'b0);
      check("t1_dout", dout, (k > 16) ? W'(k - 16) : '0);
      check("t1_primed", W'(primed), W'(k >= 16));
    end

    // T2: sparse enables after a flush
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      step((i % 3) == 0, {4'($urandom), $urandom, $urandom}, 1'b0, 5'd0, 1'b0);
    end

    // T3: load length 5 with en in the same cycle; marker must never appear
    step(1'b1, 68'hDEAD, 1'b1, 5'd5, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, W'(200 + i), 1'b0, 5'd0, 1'b0);
      check("t3_dout", dout, (i > 5) ? W'(200 + i - 5) : '0);
      check("t3_primed", W'(primed), W'(i >= 5));
    end

    // T4/T5 table
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].din, vecs[i].ld, vecs[i].len, vecs[i].flush);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_primed", i), W'(primed), W'(vecs[i].exp_primed));
      check($sformatf("vec%0d_cfg_err", i), W'(cfg_err), W'(vecs[i].exp_err));
    end
    // Over-range load behaves as length 16
    for (int i = 2; i <= 20; i++) begin
      step(1'b1, W'(300 + i), 1'b0, 5'd0, 1'b0);
      check("t5_primed", W'(primed), W'(i >= 16));
    end
    step(1'b0, '0, 1'b1, 5'd8, 1'b0);
    check("t5_err_clear", W'(cfg_err), '0);

    // T6: async reset mid-RUN with cfg_err set
    step(1'b0, '0, 1'b1, 5'd20, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, W'(400 + i), 1'b0, 5'd0, 1'b0);
    step(1'b0, '0, 1'b0, 5'd0, 1'b0);
    #1 nGrst = 1'b0;
    #1;
    check("t6_rst_dout", dout, '0);
    check("t6_rst_primed", W'(primed), '0);
    check("t6_rst_cfg_err", W'(cfg_err), '0);
    model_reset();
    #1 nGrst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, W'(500 + i), 1'b0, 5'd0, 1'b0);
      check("t6_refill_primed", W'(primed), W'(i >= 16));
    end
    // Flush mid-RUN keeps length 16
    step(1'b1, 68'hBAD, 1'b0, 5'd0, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, W'(600 + i), 1'b0, 5'd0, 1'b0);
      check("t6_flush_dout", dout, (i > 16) ? W'(600 + i - 16) : '0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step($urandom_range(0, 3) != 0, {4'($urandom), $urandom, $urandom},
           (r < 3) || (r == 6), 5'($urandom_range(0, 20)), (r >= 3) && (r <= 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
